// File: rtl/dcache_pkg.sv
// Shared definitions for the memory-stage data cache: controller state
// encoding and the address-field widths derived from the cache geometry.
package dcache_pkg;

   // Controller states
   localparam logic [1:0] ST_IDLE  = 2'd0;  // evaluate the presented access
   localparam logic [1:0] ST_FILL  = 2'd1;  // line fill outstanding to memory
   localparam logic [1:0] ST_WRITE = 2'd2;  // write-through word outstanding
   localparam logic [1:0] ST_WDONE = 2'd3;  // one-cycle release after a store

   // Word-offset field width (geometry is expected to have at least 2 words per line)
   function automatic int off_bits(input int words);
      return $clog2(words);
   endfunction

   // Line-index field width
   function automatic int idx_bits(input int lines);
      return $clog2(lines);
   endfunction

   // Tag width: whatever remains above byte offset, word offset and index
   function automatic int tag_bits(input int lines, input int words);
      return 32 - 2 - $clog2(words) - $clog2(lines);
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped data cache.
// One combinational read port (whole line), one write port that either
// installs a complete line (fill) or updates a single word (store hit).
// Valid bits are flops cleared by reset; tags and data are never reset.
module dcache_array
   import dcache_pkg::*;
#(
   parameter  int LINES = 64,
   parameter  int WORDS = 4,
   localparam int OFF_W = off_bits(WORDS),
   localparam int IDX_W = idx_bits(LINES),
   localparam int TAG_W = tag_bits(LINES, WORDS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [IDX_W-1:0]      rd_index,
   output logic                  rd_valid,
   output logic [TAG_W-1:0]      rd_tag,
   output logic [32*WORDS-1:0]   rd_line,
   input  logic [IDX_W-1:0]      wr_index,
   input  logic                  line_we,
   input  logic [TAG_W-1:0]      wr_tag,
   input  logic [32*WORDS-1:0]   wr_line,
   input  logic                  word_we,
   input  logic [OFF_W-1:0]      wr_offset,
   input  logic [31:0]           wr_word
);

   logic [LINES-1:0] valid_reg;
   logic [TAG_W-1:0] tag_mem [LINES];

   // Valid bits: cleared by reset (also aborting any fill), set when a line is installed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= '0;
      end else if (line_we) begin
         valid_reg[wr_index] <= 1'b1;
      end
   end

   // Tag storage: written only when a fill completes
   always_ff @(posedge clk) begin
      if (line_we) begin
         tag_mem[wr_index] <= wr_tag;
      end
   end

   assign rd_valid = valid_reg[rd_index];
   assign rd_tag   = tag_mem[rd_index];

   // One storage column per word of the line so a store touches only its word
   generate
      for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
         logic [31:0] word_mem [LINES];
         logic        word_sel;

         assign word_sel = word_we && (wr_offset == OFF_W'(gi));

         // Fill installs the whole line; a store hit overwrites just this word
         always_ff @(posedge clk) begin
            if (line_we) begin
               word_mem[wr_index] <= wr_line[gi*32 +: 32];
            end else if (word_sel) begin
               word_mem[wr_index] <= wr_word;
            end
         end

         assign rd_line[gi*32 +: 32] = word_mem[rd_index];
      end
   endgenerate

endmodule

// File: rtl/dcache_mem_stage.sv
// M-stage data cache controller: direct-mapped, write-through, read-allocate.
// Load hits return data combinationally with no stall. Load misses fetch a
// full line; every store is written through to memory and updates the cached
// word only on a hit. Mem_Stall holds the pipeline until the access is done.
module dcache_mem_stage
   import dcache_pkg::*;
#(
   parameter int LINES = 64,
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  MemReadM,
   input  logic                  MemWriteM,
   input  logic [31:0]           ALUoutM,
   input  logic [31:0]           RD2M,
   output logic [31:0]           ReadDataM,
   output logic                  Mem_Stall,
   output logic                  mem_rd_req,
   output logic                  mem_wr_req,
   output logic [31:0]           mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [32*WORDS-1:0]   mem_rdata,
   input  logic                  mem_ready
);

   localparam int OFF_W = off_bits(WORDS);
   localparam int IDX_W = idx_bits(LINES);
   localparam int TAG_W = tag_bits(LINES, WORDS);

   logic [1:0]          state_reg;
   logic [1:0]          state_next;

   logic [OFF_W-1:0]    addr_off;
   logic [IDX_W-1:0]    addr_idx;
   logic [TAG_W-1:0]    addr_tag;
   logic [31:0]         line_addr;

   logic                rd_valid;
   logic [TAG_W-1:0]    rd_tag;
   logic [32*WORDS-1:0] rd_line;
   logic [31:0]         line_words [WORDS];
   logic                hit;
   logic [31:0]         hit_word;

   logic                line_we;
   logic                word_we;

   // Byte-lane bits never matter: all accesses are whole words
   logic                unused_addr_bits;
   assign unused_addr_bits = ^ALUoutM[1:0];

   assign addr_off  = ALUoutM[2 +: OFF_W];
   assign addr_idx  = ALUoutM[2+OFF_W +: IDX_W];
   assign addr_tag  = ALUoutM[31 -: TAG_W];
   assign line_addr = {addr_tag, addr_idx, {(OFF_W+2){1'b0}}};

   dcache_array #(
      .LINES (LINES),
      .WORDS (WORDS)
   ) u_array (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_index  (addr_idx),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_line   (rd_line),
      .wr_index  (addr_idx),
      .line_we   (line_we),
      .wr_tag    (addr_tag),
      .wr_line   (mem_rdata),
      .word_we   (word_we),
      .wr_offset (addr_off),
      .wr_word   (RD2M)
   );

   generate
      for (genvar gi = 0; gi < WORDS; gi++) begin : g_split
         assign line_words[gi] = rd_line[gi*32 +: 32];
      end
   endgenerate

   assign hit      = rd_valid && (rd_tag == addr_tag);
   assign hit_word = line_words[addr_off];

   // State register; reset aborts any outstanding request immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state, stall, memory request and load-data generation
   always_comb begin
      state_next = state_reg;
      Mem_Stall  = 1'b0;
      mem_rd_req = 1'b0;
      mem_wr_req = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      ReadDataM  = '0;
      line_we    = 1'b0;
      word_we    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            // A simultaneous read and write is handled as a write
            if (MemWriteM) begin
               Mem_Stall  = 1'b1;
               state_next = ST_WRITE;
            end else if (MemReadM) begin
               if (hit) begin
                  ReadDataM = hit_word;
               end else begin
                  Mem_Stall  = 1'b1;
                  state_next = ST_FILL;
               end
            end
         end
         ST_FILL: begin
            mem_rd_req = 1'b1;
            mem_addr   = line_addr;
            Mem_Stall  = 1'b1;
            if (mem_ready) begin
               // Install the line; the held load then hits back in IDLE
               line_we    = 1'b1;
               state_next = ST_IDLE;
            end
         end
         ST_WRITE: begin
            mem_wr_req = 1'b1;
            mem_addr   = {ALUoutM[31:2], 2'b00};
            mem_wdata  = RD2M;
            Mem_Stall  = 1'b1;
            if (mem_ready) begin
               // Keep the cached copy coherent; misses do not allocate
               word_we    = hit;
               state_next = ST_WDONE;
            end
         end
         ST_WDONE: begin
            // Stall drops for this one cycle so the store retires
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dcache_mem_stage.sv
// Scoreboard bench for dcache_mem_stage: a driver issues loads/stores and
// pushes expected memory requests and completions; a memory responder serves
// requests with per-transaction latency; a monitor pops and compares.
module tb_dcache_mem_stage;

   localparam int LINES = 64;
   localparam int WORDS = 4;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                MemReadM = 1'b0;
   logic                MemWriteM = 1'b0;
   logic [31:0]         ALUoutM = '0;
   logic [31:0]         RD2M = '0;
   logic [31:0]         ReadDataM;
   logic                Mem_Stall;
   logic                mem_rd_req;
   logic                mem_wr_req;
   logic [31:0]         mem_addr;
   logic [31:0]         mem_wdata;
   logic [32*WORDS-1:0] mem_rdata = '0;
   logic                mem_ready = 1'b0;

   always #5 clk = ~clk;

   dcache_mem_stage #(
      .LINES (LINES),
      .WORDS (WORDS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .MemReadM   (MemReadM),
      .MemWriteM  (MemWriteM),
      .ALUoutM    (ALUoutM),
      .RD2M       (RD2M),
      .ReadDataM  (ReadDataM),
      .Mem_Stall  (Mem_Stall),
      .mem_rd_req (mem_rd_req),
      .mem_wr_req (mem_wr_req),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   typedef struct {
      bit          is_load;
      logic [31:0] addr;
      logic [31:0] data;
      int          stalls;
   } txn_t;

   typedef struct {
      bit          is_rd;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   txn_t        txn_q[$];
   req_t        req_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          cur_lat = 1;

   // Reference model: flat word memory plus which line each cache slot holds
   logic [31:0] ref_mem [logic [31:0]];
   bit          mdl_valid [LINES];
   logic [21:0] mdl_tag [LINES];

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (ref_mem.exists(w)) return ref_mem[w];
      return (w * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic finish_sim();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   endtask

   // Memory responder: ready after cur_lat request cycles, spurious ready otherwise
   int req_cnt = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         req_cnt   = 0;
         mem_ready = 1'b0;
      end else if (mem_rd_req || mem_wr_req) begin
         req_cnt++;
         mem_ready = (req_cnt >= cur_lat);
         if (mem_ready) req_cnt = 0;
         for (int w = 0; w < WORDS; w++)
            mem_rdata[w*32 +: 32] = ref_word(mem_addr + 32'(4*w));
      end else begin
         req_cnt   = 0;
         mem_ready = ($urandom_range(0, 3) == 0);
         for (int w = 0; w < WORDS; w++)
            mem_rdata[w*32 +: 32] = $urandom;
      end
   end

   // Monitor: pops expected requests/completions whenever the DUT presents them
   int stall_cnt = 0;
   always begin
      req_t r;
      txn_t t;
      @(negedge clk);
      #2;
      if (!rst_n) begin
         stall_cnt = 0;
      end else begin
         check("req_exclusive", 64'(mem_rd_req & mem_wr_req), 64'd0);
         if ((mem_rd_req || mem_wr_req) && mem_ready) begin
            if (req_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_req: got rd=%0b wr=%0b addr=%h expected none", mem_rd_req, mem_wr_req, mem_addr);
            end else begin
               r = req_q.pop_front();
               check("req_kind", 64'(mem_rd_req), 64'(r.is_rd));
               check("req_addr", 64'(mem_addr), 64'(r.addr));
               if (!r.is_rd) check("req_wdata", 64'(mem_wdata), 64'(r.wdata));
            end
         end
         if (MemReadM || MemWriteM) begin
            if (Mem_Stall) begin
               stall_cnt++;
            end else if (txn_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_done: got completion at addr %h expected none", ALUoutM);
            end else begin
               t = txn_q.pop_front();
               check("stall_cycles", 64'(stall_cnt), 64'(t.stalls));
               if (t.is_load) check("load_data", 64'(ReadDataM), 64'(t.data));
               check("done_no_req", 64'({mem_rd_req, mem_wr_req}), 64'd0);
               stall_cnt = 0;
            end
         end else begin
            check("idle_outputs", {29'd0, Mem_Stall, mem_rd_req, mem_wr_req, ReadDataM}, 64'd0);
         end
      end
   end

   // Issue one access, predict its requests/stall/data, wait until it retires
   task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input int lat);
      txn_t        t;
      req_t        r;
      int          guard;
      logic [5:0]  idx;
      logic [21:0] tg;
      idx = a[9:4];
      tg  = a[31:10];
      cur_lat  = lat;
      t.addr   = a;
      t.data   = '0;
      if (wr) begin
         r.is_rd = 1'b0;
         r.addr  = {a[31:2], 2'b00};
         r.wdata = d;
         req_q.push_back(r);
         ref_mem[{a[31:2], 2'b00}] = d;
         t.is_load = 1'b0;
         t.stalls  = 1 + lat;
      end else begin
         t.is_load = 1'b1;
         t.data    = ref_word(a);
         if (mdl_valid[idx] && mdl_tag[idx] == tg) begin
            t.stalls = 0;
         end else begin
            t.stalls = 1 + lat;
            r.is_rd  = 1'b1;
            r.addr   = {a[31:4], 4'b0000};
            r.wdata  = '0;
            req_q.push_back(r);
            mdl_valid[idx] = 1'b1;
            mdl_tag[idx]   = tg;
         end
      end
      txn_q.push_back(t);
      MemReadM  = rd;
      MemWriteM = wr;
      ALUoutM   = a;
      RD2M      = d;
      $display("txn %s addr=%h data=%h lat=%0d", wr ? "ST" : "LD", a, wr ? d : t.data, lat);
      guard = 0;
      forever begin
         @(negedge clk);
         #3;
         if (!Mem_Stall) break;
         guard++;
         if (guard > 60) begin
            vectors++;
            miscompares++;
            $display("FAIL stall_timeout: got stall still high after %0d cycles expected release", guard);
            finish_sim();
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      MemReadM  = 1'b0;
      MemWriteM = 1'b0;
      ALUoutM   = $urandom;
      RD2M      = $urandom;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int op;
      logic [31:0] a;
      for (int i = 0; i < LINES; i++) begin
         mdl_valid[i] = 1'b0;
         mdl_tag[i]   = '0;
      end
      // Reset state
      #12;
      check("reset_stall", 64'(Mem_Stall), 64'd0);
      check("reset_reqs", 64'({mem_rd_req, mem_wr_req}), 64'd0);
      check("reset_rdata", 64'(ReadDataM), 64'd0);
      check("reset_addr_wdata", {mem_addr, mem_wdata}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_cycle();

      // Directed scenarios
      ref_mem[32'h100] = 32'h11;
      ref_mem[32'h104] = 32'h22;
      ref_mem[32'h108] = 32'h33;
      ref_mem[32'h10C] = 32'h44;
      issue(1, 0, 32'h0000_0104, 32'h0, 3);          // cold miss, stall 4, 0x22
      issue(1, 0, 32'h0000_010C, 32'h0, 1);          // hit, 0x44
      issue(0, 1, 32'h0000_0108, 32'hDEAD_BEEF, 1);  // store hit, stall 2
      issue(1, 0, 32'h0000_0108, 32'h0, 1);          // hit returns stored word
      issue(0, 1, 32'h0000_2000, 32'hCAFE_F00D, 2);  // store miss, no allocate
      issue(1, 0, 32'h0000_2000, 32'h0, 2);          // must miss
      issue(1, 0, 32'h0000_0100, 32'h0, 1);          // still cached
      issue(1, 0, 32'h0000_0500, 32'h0, 2);          // conflict eviction
      issue(1, 0, 32'h0000_0100, 32'h0, 1);          // misses again
      issue(0, 1, 32'h0000_0104, 32'h1234_0001, 1);  // back-to-back stores
      issue(0, 1, 32'h0000_010C, 32'h1234_0002, 3);
      issue(1, 1, 32'h0000_0200, 32'h1234_0003, 1);  // read+write treated as write
      issue(1, 0, 32'h0000_010C, 32'h0, 1);
      idle_cycle();

      // Reset during the second FILL cycle of a miss
      cur_lat   = 10;
      MemReadM  = 1'b1;
      ALUoutM   = 32'h0000_0900;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #3;
      end
      check("fill_before_reset", {31'd0, mem_rd_req, mem_addr}, {31'd0, 1'b1, 32'h0000_0900});
      rst_n = 1'b0;
      #1;
      check("reset_drops_req", 64'({mem_rd_req, mem_wr_req}), 64'd0);
      MemReadM = 1'b0;
      txn_q.delete();
      req_q.delete();
      for (int i = 0; i < LINES; i++) mdl_valid[i] = 1'b0;
      $display("txn RESET during fill");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_cycle();
      issue(1, 0, 32'h0000_0100, 32'h0, 2);          // everything invalidated
      issue(1, 0, 32'h0000_0900, 32'h0, 1);          // aborted fill left nothing

      // Randomized traffic over a small address pool to force hits and conflicts
      for (int n = 0; n < 400; n++) begin
         op = $urandom_range(0, 9);
         a  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4)
            | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         if (op <= 4)      issue(1, 0, a, $urandom, $urandom_range(1, 4));
         else if (op <= 7) issue(0, 1, a, $urandom, $urandom_range(1, 4));
         else if (op == 8) issue(1, 1, a, $urandom, $urandom_range(1, 4));
         else              idle_cycle();
      end
      idle_cycle();
      idle_cycle();
      if (txn_q.size() != 0 || req_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL leftover_expectations: got %0d txn %0d req pending expected 0", txn_q.size(), req_q.size());
      end
      finish_sim();
   end

endmodule

// File: doc/dcache_mem_stage.md
# dcache_mem_stage

Memory-stage data cache controller for the five-stage RISC-V pipeline. Consumes the M-stage control and data registered by the E→M pipeline register: address, store data, read and write enables. Serves loads from a direct-mapped, write-through, read-allocate cache and forwards misses and all stores to main memory through a req/ready handshake. Drives `Mem_Stall`, which freezes the E→M register and all upstream stages until the access completes.

## Interface
- `LINES`, 64: number of cache lines (power of two).
- `WORDS`, 4: 32-bit words per line (power of two).
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `MemReadM`, input, 1: load request.
- `MemWriteM`, input, 1: store request.
- `ALUoutM`, input, 32: byte address; bits [1:0] ignored (word accesses only).
- `RD2M`, input, 32: store data.
- `ReadDataM`, output, 32: load data, valid when `MemReadM` is 1 and `Mem_Stall` is 0.
- `Mem_Stall`, output, 1: pipeline hold.
- `mem_rd_req`, output, 1: line-fill request.
- `mem_wr_req`, output, 1: word-write request.
- `mem_addr`, output, 32: line-aligned for fills, word-aligned for writes.
- `mem_wdata`, output, 32: store word.
- `mem_rdata`, input, 32·WORDS: fill line, word 0 in the LSBs.
- `mem_ready`, input, 1: completes the pending request in this cycle.

## Operation
- Address split, with LINES=64 and WORDS=4: offset = [3:2], index = [9:4], tag = [31:10]. The general split is offset log2(WORDS) bits starting at bit 2, then index log2(LINES) bits, then the tag in the remaining bits.
- Storage per line: valid bit (flop, reset to 0), tag, and data words. Tag and data storage are not reset.
- Hit means valid[index] is set and the stored tag equals the address tag.
- FSM states: IDLE, FILL, WRITE, WDONE.
- IDLE with a read hit: `ReadDataM` = cached word combinationally, `Mem_Stall` = 0, state stays IDLE.
- IDLE with a read miss: `Mem_Stall` = 1, next state FILL.
- IDLE with a write (hit or miss): `Mem_Stall` = 1, next state WRITE.
- IDLE with no request: `Mem_Stall` = 0.
- FILL: `mem_rd_req` = 1, `mem_addr` = {tag, index, 0…}, `Mem_Stall` = 1. On `mem_ready`: write the line data and tag, set valid, go to IDLE. In IDLE the held request re-evaluates as a hit.
- WRITE: `mem_wr_req` = 1, `mem_addr` = {ALUoutM[31:2], 2'b00}, `mem_wdata` = `RD2M`, `Mem_Stall` = 1. On `mem_ready`: if the address hits, update the cached word (write-through). A write miss does not allocate. Next state WDONE.
- WDONE: `Mem_Stall` = 0 for exactly one cycle so the pipeline advances past the store, with no memory request. Next state IDLE.
- If `MemReadM` and `MemWriteM` are both set, the request is treated as a write.
- `mem_ready` is ignored in IDLE and WDONE.
- When idle, `mem_addr`, `mem_wdata` and `ReadDataM` are don't-care but must not be X. Drive 0.

## Timing
- Reset values: state = IDLE, all valid bits = 0, `mem_rd_req` = 0, `mem_wr_req` = 0, `Mem_Stall` = 0 (when no request is present), `ReadDataM` = 0.
- Load hit: 0 stall cycles.
- Load miss: stall lasts 1 + N cycles, where N is the number of FILL cycles up to and including `mem_ready`.
- Store: stall lasts 1 + N cycles, where N is the number of WRITE cycles; release happens in WDONE.
- `mem_rd_req` and `mem_wr_req` stay asserted with stable address and data until the `mem_ready` cycle. They deassert in the following cycle and are never both high.
- Reset mid-FILL or mid-WRITE: return to IDLE immediately, drop the request, and invalidate all lines. The interrupted fill leaves no valid line.
- Two back-to-back stores: the second enters WRITE the cycle after WDONE→IDLE, with no bubble beyond the IDLE evaluation cycle.

## Structure
- Shared package `dcache_pkg` holds the FSM state encoding and the localparam functions for offset, index and tag widths derived from LINES and WORDS.
- One sub-module: `dcache_array`, which holds the valid, tag and data storage with one read port and one line/word write port. The controller FSM, hit compare and output muxing stay in `dcache_mem_stage`.

## Test plan
- Cold load from 0x0000_0104, memory returns `mem_ready` on the 3rd FILL cycle with line {0x44, 0x33, 0x22, 0x11}: `mem_addr` = 0x0000_0100, `Mem_Stall` high for 4 cycles, then `ReadDataM` = 0x22.
- After that fill, a load from 0x0000_010C: no stall, `ReadDataM` = 0x44, no memory request.
- Store 0xDEAD_BEEF to 0x0000_0108 with `mem_ready` on the 1st WRITE cycle: stall high 2 cycles, WDONE has stall low, then a load from 0x108 hits and returns 0xDEAD_BEEF.
- Store to an uncached address 0x0000_2000: memory write only. A subsequent load from 0x2000 misses and FILL is issued.
- Conflict: load 0x0000_0100, then load 0x0000_0500 (same index, different tag): second load misses and refills. A load from 0x100 then misses again.
- Assert `rst_n` low during the 2nd FILL cycle: requests drop in the same cycle. After release, a load from 0x100 misses.
